// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, buffers {pc, instruction} pairs for decode.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirects via Fetch_Fault.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2,
  parameter int          PC_STEP    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Fetch_Enable,
  output logic [63:0]                  Inst_Address,
  input  logic [31:0]                  Instruction,
  input  logic                         Redirect_Valid,
  input  logic [63:0]                  Redirect_Target,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [63:0]                  Out_PC,
  output logic [31:0]                  Out_Instruction,
  output logic [$clog2(FIFO_DEPTH):0]  Fetch_Count
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic                         Fetch_Fault
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } fetch_t;

  fetch_t          mem [FIFO_DEPTH];
  fetch_t          head_q;
  fetch_t          head_d;
  logic [63:0]     pc_q;
  logic [63:0]     pc_d;
  logic [63:0]     redir_pc;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   remain;
  logic            full;
  logic            push;
  logic            pop;
  logic            blocked;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (Redirect_Valid) begin
      fault_q <= |Redirect_Target[1:0];
    end
  end

  assign Fetch_Fault = fault_q;
  assign blocked     = fault_q;
  assign redir_pc    = Redirect_Target;
`else
  logic unused_tgt;

  assign unused_tgt = ^Redirect_Target[1:0];
  assign blocked    = 1'b0;
  assign redir_pc   = {Redirect_Target[63:2], 2'b00};
`endif

  assign full   = (cnt == CW'(FIFO_DEPTH));
  assign pop    = Out_Valid & Out_Ready;
  assign push   = Fetch_Enable & ~Redirect_Valid & ~blocked
                & (~full | pop);
  assign remain = cnt - CW'(pop);
  assign rd_nxt = rd_ptr + PW'(pop);

  // Head register preloads the entry that will be at the head after
  // this edge, so a push into an empty buffer is visible next cycle.
  always_comb begin
    pc_d   = pc_q;
    head_d = head_q;
    unique case (1'b1)
      Redirect_Valid: begin
        pc_d   = redir_pc;
        head_d = '0;
      end
      default: begin
        if (push) begin
          pc_d = pc_q + 64'(PC_STEP);
        end
        if (remain != '0) begin
          head_d = mem[rd_nxt];
        end else if (push) begin
          head_d = '{pc: pc_q, ins: Instruction};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      head_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      pc_q   <= pc_d;
      head_q <= head_d;
      if (Redirect_Valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_nxt;
        cnt    <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: pc_q, ins: Instruction};
    end
  end

  assign Inst_Address    = pc_q;
  assign Out_Valid       = (cnt != '0);
  assign Out_PC          = head_q.pc;
  assign Out_Instruction = head_q.ins;
  assign Fetch_Count     = cnt;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit.
// Mirrors IFU_MISALIGN_TRAP_EN to pick the misaligned-redirect scenario.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe;
  logic        rv;
  logic [63:0] rt;
  logic        ordy;
  logic [63:0] ia;
  logic [31:0] ins;
  logic        ov;
  logic [63:0] opc;
  logic [31:0] oins;
  logic [1:0]  fc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fault;
`endif

  logic        fe2;
  logic        rv2;
  logic [63:0] rt2;
  logic        ordy2;
  logic [63:0] ia2;
  logic [31:0] ins2;
  logic        ov2;
  logic [63:0] opc2;
  logic [31:0] oins2;
  logic [1:0]  fc2;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fault2;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h02853483;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
  endfunction

  assign ins  = mem_word(ia);
  assign ins2 = mem_word(ia2);

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (rst),
    .Fetch_Enable    (fe),
    .Inst_Address    (ia),
    .Instruction     (ins),
    .Redirect_Valid  (rv),
    .Redirect_Target (rt),
    .Out_Valid       (ov),
    .Out_Ready       (ordy),
    .Out_PC          (opc),
    .Out_Instruction (oins),
    .Fetch_Count     (fc)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .Fetch_Fault     (fault)
`endif
  );

  instruction_fetch_unit #(
    .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
  ) u_wrap (
    .clk             (clk),
    .reset           (rst),
    .Fetch_Enable    (fe2),
    .Inst_Address    (ia2),
    .Instruction     (ins2),
    .Redirect_Valid  (rv2),
    .Redirect_Target (rt2),
    .Out_Valid       (ov2),
    .Out_Ready       (ordy2),
    .Out_PC          (opc2),
    .Out_Instruction (oins2),
    .Fetch_Count     (fc2)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .Fetch_Fault     (fault2)
`endif
  );

  task automatic test_reset;
    rst = 1'b0; fe = 1'b0; rv = 1'b0; rt = '0; ordy = 1'b0;
    fe2 = 1'b0; rv2 = 1'b0; rt2 = '0; ordy2 = 1'b0;
    @(negedge clk);
    checks++;
    if (ia !== 64'h0 || ov !== 1'b0 || fc !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctl ia=%h ov=%b fc=%0d want 0/0/0", ia, ov, fc);
    end
    checks++;
    if (opc !== 64'h0 || oins !== 32'h0) begin
      errors++;
      $display("FAIL reset_out pc=%h ins=%h want 0/0", opc, oins);
    end
    rst = 1'b1;
  endtask

  task automatic test_stream;
    logic [63:0] e;
    @(negedge clk);
    checks++;
    if (ia !== 64'h0) begin
      errors++;
      $display("FAIL stream_idle ia=%h want 0", ia);
    end
    fe = 1'b1; ordy = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(4 * i));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (ia !== 64'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr ia=%h want %h", ia, 64'(4 * i));
      end
      checks++;
      if (ov !== 1'b1 || fc !== 2'd1) begin
        errors++;
        $display("FAIL stream_occ ov=%b fc=%0d want 1/1", ov, fc);
      end
      if (i == 1) begin
        checks++;
        if (oins !== 32'h02853483) begin
          errors++;
          $display("FAIL stream_word0 ins=%h want 02853483", oins);
        end
      end
      if (ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_sb got pc=%h want none", opc);
        end else begin
          e = exp_q.pop_front();
          if (opc !== e || oins !== mem_word(e)) begin
            errors++;
            $display("FAIL stream_sb got %h/%h want %h/%h",
                     opc, oins, e, mem_word(e));
          end
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [63:0] e;
    logic [1:0]  ec;
    logic [63:0] ea;
    @(negedge clk);
    rv = 1'b1; rt = 64'h0; ordy = 1'b0;
    @(negedge clk);
    checks++;
    if (ov !== 1'b0 || fc !== 2'd0 || ia !== 64'h0) begin
      errors++;
      $display("FAIL stall_flush ov=%b fc=%0d ia=%h want 0/0/0", ov, fc, ia);
    end
    rv = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(64'(4 * i));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ec = (k < 2) ? 2'(k) : 2'd2;
      ea = (k < 2) ? 64'(4 * k) : 64'h8;
      checks++;
      if (fc !== ec || ia !== ea) begin
        errors++;
        $display("FAIL stall_hold fc=%0d ia=%h want %0d/%h", fc, ia, ec, ea);
      end
      checks++;
      if (ov !== 1'b1 || opc !== 64'h0) begin
        errors++;
        $display("FAIL stall_head ov=%b pc=%h want 1/0", ov, opc);
      end
      if (k == 5) ordy = 1'b1;
      if (ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stall_sb got pc=%h want none", opc);
        end else begin
          e = exp_q.pop_front();
          if (opc !== e || oins !== mem_word(e)) begin
            errors++;
            $display("FAIL stall_sb got %h/%h want %h/%h",
                     opc, oins, e, mem_word(e));
          end
        end
      end
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checks++;
      if (fc !== 2'd2) begin
        errors++;
        $display("FAIL stall_drain fc=%0d want 2", fc);
      end
      if (ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stall_sb got pc=%h want none", opc);
        end else begin
          e = exp_q.pop_front();
          if (opc !== e || oins !== mem_word(e)) begin
            errors++;
            $display("FAIL stall_sb got %h/%h want %h/%h",
                     opc, oins, e, mem_word(e));
          end
        end
      end
    end
  endtask

  task automatic test_full_pushpop;
    logic [63:0] e;
    logic [63:0] prev;
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(12 + 4 * i));
    prev = ia;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (fc !== 2'd2 || ia !== prev + 64'd4) begin
        errors++;
        $display("FAIL full_step fc=%0d ia=%h want 2/%h", fc, ia, prev + 64'd4);
      end
      prev = ia;
      if (ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL full_sb got pc=%h want none", opc);
        end else begin
          e = exp_q.pop_front();
          if (opc !== e || oins !== mem_word(e)) begin
            errors++;
            $display("FAIL full_sb got %h/%h want %h/%h",
                     opc, oins, e, mem_word(e));
          end
        end
      end
    end
  endtask

  task automatic test_redirect;
    logic [63:0] e;
    rv = 1'b1; rt = 64'h8;
    @(negedge clk);
    checks++;
    if (ov !== 1'b0 || fc !== 2'd0 || ia !== 64'h8) begin
      errors++;
      $display("FAIL redir_flush ov=%b fc=%0d ia=%h want 0/0/8", ov, fc, ia);
    end
    rv = 1'b0;
    exp_q.push_back(64'h8);
    @(negedge clk);
    checks++;
    if (ov !== 1'b1 || opc !== 64'h8) begin
      errors++;
      $display("FAIL redir_first ov=%b pc=%h want 1/8", ov, opc);
    end
    if (ov && ordy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL redir_sb got pc=%h want none", opc);
      end else begin
        e = exp_q.pop_front();
        if (opc !== e || oins !== mem_word(e)) begin
          errors++;
          $display("FAIL redir_sb got %h/%h want %h/%h",
                   opc, oins, e, mem_word(e));
        end
      end
    end
    fe = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (ov !== 1'b0 || fc !== 2'd0 || ia !== 64'hC) begin
        errors++;
        $display("FAIL fe_low ov=%b fc=%0d ia=%h want 0/0/c", ov, fc, ia);
      end
    end
  endtask

  task automatic test_misalign;
    logic [63:0] e;
    rv = 1'b1; rt = 64'h6; fe = 1'b1; ordy = 1'b1;
    @(negedge clk);
`ifdef IFU_MISALIGN_TRAP_EN
    checks++;
    if (ia !== 64'h6 || fault !== 1'b1 || ov !== 1'b0) begin
      errors++;
      $display("FAIL trap_set ia=%h flt=%b ov=%b want 6/1/0", ia, fault, ov);
    end
    rv = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (fc !== 2'd0 || ia !== 64'h6 || fault !== 1'b1) begin
        errors++;
        $display("FAIL trap_block fc=%0d ia=%h flt=%b want 0/6/1", fc, ia, fault);
      end
    end
    rv = 1'b1; rt = 64'h10;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || ia !== 64'h10) begin
      errors++;
      $display("FAIL trap_clear flt=%b ia=%h want 0/10", fault, ia);
    end
    rv = 1'b0;
    exp_q.push_back(64'h10);
`else
    checks++;
    if (ia !== 64'h4) begin
      errors++;
      $display("FAIL align_pc ia=%h want 4", ia);
    end
    rv = 1'b0;
    exp_q.push_back(64'h4);
`endif
    @(negedge clk);
    checks++;
    if (ov !== 1'b1) begin
      errors++;
      $display("FAIL misalign_resume ov=%b want 1", ov);
    end
    if (ov && ordy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL misalign_sb got pc=%h want none", opc);
      end else begin
        e = exp_q.pop_front();
        if (opc !== e || oins !== mem_word(e)) begin
          errors++;
          $display("FAIL misalign_sb got %h/%h want %h/%h",
                   opc, oins, e, mem_word(e));
        end
      end
    end
    fe = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rv = 1'b1; rt = 64'hFFFF_FFFF_FFFF_FFF8; ordy = 1'b0; fe = 1'b0;
    @(negedge clk);
    checks++;
    if (ia !== 64'hFFFF_FFFF_FFFF_FFF8 || fc !== 2'd0) begin
      errors++;
      $display("FAIL mid_setup ia=%h fc=%0d want fff8/0", ia, fc);
    end
    rv = 1'b0; fe = 1'b1;
    @(negedge clk);
    checks++;
    if (ia !== 64'hFFFF_FFFF_FFFF_FFFC || fc !== 2'd1
        || opc !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      errors++;
      $display("FAIL mid_pre ia=%h fc=%0d pc=%h want fffc/1/fff8", ia, fc, opc);
    end
    fe = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ia !== 64'h0 || ov !== 1'b0 || opc !== 64'h0
        || oins !== 32'h0 || fc !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset ia=%h ov=%b pc=%h ins=%h fc=%0d want all 0",
               ia, ov, opc, oins, fc);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    checks++;
    if (ia2 !== 64'hFFFF_FFFF_FFFF_FFFC || fc2 !== 2'd0) begin
      errors++;
      $display("FAIL wrap_reset ia=%h fc=%0d want fffc/0", ia2, fc2);
    end
    rst = 1'b1; fe2 = 1'b1;
    @(negedge clk);
    checks++;
    if (ia2 !== 64'h0 || fc2 !== 2'd1) begin
      errors++;
      $display("FAIL wrap_pc ia=%h fc=%0d want 0/1", ia2, fc2);
    end
    checks++;
    if (opc2 !== 64'hFFFF_FFFF_FFFF_FFFC
        || oins2 !== mem_word(64'hFFFF_FFFF_FFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_head pc=%h ins=%h want fffc/%h",
               opc2, oins2, mem_word(64'hFFFF_FFFF_FFFF_FFFC));
    end
    fe2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_full_pushpop();
    test_redirect();
    test_misalign();
    test_reset_mid();
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover have %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
